// File: rtl/nes_pad_responder_if.sv
// Pad-side bus of nes_pad_responder: host pins, button source and read status.
// master = host/button-source side, slave = the responder itself.
interface nes_pad_responder_if;
  logic       i_data_latch;
  logic       i_data_clock;
  logic [7:0] i_button_state;
  logic [1:0] i_turbo;
  logic       o_serial_data;
  logic [3:0] o_bit_index;
  logic       o_read_done;

  modport master (
    output i_data_latch, i_data_clock, i_button_state, i_turbo,
    input  o_serial_data, o_bit_index, o_read_done
  );

  modport slave (
    input  i_data_latch, i_data_clock, i_button_state, i_turbo,
    output o_serial_data, o_bit_index, o_read_done
  );
endinterface

// File: rtl/nes_pad_responder.sv
// NES gamepad (4021-style) responder: synchronises host latch/clock and shifts out 8 buttons.
// Optional turbo masking on A/B is built only when NESPAD_TURBO_EN is defined.
module nes_pad_responder #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned TURBO_PERIOD = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  nes_pad_responder_if.slave  bus
);

  localparam int unsigned SR_W  = 8;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [IDX_W-1:0]  bit_index;
  logic              serial_data;
  logic              read_done;
  logic [SR_W-1:0]   masked;

  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] clock_sync;
  logic                   latch_prev;
  logic                   clock_prev;
  logic                   latch_s;
  logic                   clock_s;
  logic                   latch_rise;
  logic                   latch_fall;
  logic                   clock_rise;

  // Host pins are asynchronous: synchronise, then one flop for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      latch_sync <= '0;
      clock_sync <= '0;
      latch_prev <= 1'b0;
      clock_prev <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], bus.i_data_latch};
      clock_sync <= {clock_sync[SYNC_STAGES-2:0], bus.i_data_clock};
      latch_prev <= latch_s;
      clock_prev <= clock_s;
    end
  end

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign clock_s    = clock_sync[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_prev;
  assign latch_fall = ~latch_s & latch_prev;
  assign clock_rise = clock_s & ~clock_prev;

`ifdef NESPAD_TURBO_EN
  localparam int unsigned CNT_W = $clog2(TURBO_PERIOD) + 1;

  logic [CNT_W-1:0] fall_cnt;
  logic             turbo_phase;

  // Phase flips after every TURBO_PERIOD latch falls, whatever state we are in
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fall_cnt    <= '0;
      turbo_phase <= 1'b0;
    end else if (latch_fall) begin
      if (fall_cnt == CNT_W'(TURBO_PERIOD - 1)) begin
        fall_cnt    <= '0;
        turbo_phase <= ~turbo_phase;
      end else begin
        fall_cnt <= fall_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    masked = bus.i_button_state;
    if (!turbo_phase) begin
      if (bus.i_turbo[0]) masked[0] = 1'b0;
      if (bus.i_turbo[1]) masked[1] = 1'b0;
    end
  end
`else
  localparam int unsigned unused_turbo_period = TURBO_PERIOD;
  logic unused_turbo;

  assign unused_turbo = ^bus.i_turbo;

  always_comb begin
    masked = bus.i_button_state;
  end
`endif

  // Read FSM; a latch rise (or latch already high out of IDLE) always restarts in LOAD
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      sr          <= '1;
      bit_index   <= '0;
      serial_data <= 1'b1;
      read_done   <= 1'b0;
    end else begin
      read_done <= 1'b0;
      if (latch_rise || (state == ST_IDLE && latch_s)) begin
        state       <= ST_LOAD;
        sr          <= ~masked;
        serial_data <= ~masked[0];
        bit_index   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            sr          <= '1;
            serial_data <= 1'b1;
            bit_index   <= '0;
          end
          ST_LOAD: begin
            if (latch_fall) begin
              // Latch fall wins over a coincident clock edge; sr stays frozen
              state       <= ST_SHIFT;
              bit_index   <= '0;
              serial_data <= sr[0];
            end else begin
              sr          <= ~masked;
              serial_data <= ~masked[0];
            end
          end
          ST_SHIFT: begin
            if (clock_rise) begin
              sr        <= {1'b0, sr[SR_W-1:1]};
              bit_index <= bit_index + IDX_W'(1);
              if (bit_index == IDX_W'(SR_W - 1)) begin
                state       <= ST_DONE;
                serial_data <= 1'b0;
                read_done   <= 1'b1;
              end else begin
                serial_data <= sr[1];
              end
            end
          end
          ST_DONE: begin
            serial_data <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.o_serial_data = serial_data;
  assign bus.o_bit_index   = bit_index;
  assign bus.o_read_done   = read_done;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Self-checking bench for nes_pad_responder: host-side read model with an expected-bit queue.
module tb_nes_pad_responder;

`ifdef NESPAD_TURBO_EN
  localparam int unsigned TP = 2;
`else
  localparam int unsigned TP = 4;
`endif
  localparam int unsigned HALF = 8;

  logic i_clk = 1'b0;
  logic i_rst;
  int   errors = 0;
  int   checks = 0;
  int   done_count = 0;
  logic exp_q[$];

  nes_pad_responder_if bus ();

  nes_pad_responder #(
    .SYNC_STAGES  (2),
    .TURBO_PERIOD (TP)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (bus.o_read_done === 1'b1) done_count++;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic host_latch();
    bus.i_data_latch = 1'b1;
    wait_cyc(HALF);
    bus.i_data_latch = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic host_clock();
    bus.i_data_clock = 1'b1;
    wait_cyc(HALF);
    bus.i_data_clock = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic push_read(input logic [7:0] buttons);
    for (int i = 0; i < 8; i++) exp_q.push_back(~buttons[i]);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    bus.i_data_latch = 1'b0;
    bus.i_data_clock = 1'b0;
    bus.i_button_state = 8'h00;
    bus.i_turbo = 2'b00;
    wait_cyc(3);
    i_rst = 1'b0;
    wait_cyc(1);
    checks++;
    if (bus.o_serial_data !== 1'b1) begin
      errors++; $display("FAIL reset_serial: got %b want 1", bus.o_serial_data);
    end
    checks++;
    if (bus.o_bit_index !== 4'd0) begin
      errors++; $display("FAIL reset_index: got %0d want 0", bus.o_bit_index);
    end
    checks++;
    if (bus.o_read_done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b want 0", bus.o_read_done);
    end
  endtask

  task automatic test_basic_read();
    int   d0;
    logic e;
    bus.i_button_state = 8'b0000_1001;
    push_read(8'b0000_1001);
    d0 = done_count;
    host_latch();
    checks++;
    if (bus.o_bit_index !== 4'd0) begin
      errors++; $display("FAIL basic_index0: got %0d want 0", bus.o_bit_index);
    end
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.o_serial_data !== e) begin
        errors++; $display("FAIL basic_bit%0d: got %b want %b", i, bus.o_serial_data, e);
      end
      host_clock();
    end
    checks++;
    if (bus.o_serial_data !== 1'b0) begin
      errors++; $display("FAIL basic_after: got %b want 0", bus.o_serial_data);
    end
    checks++;
    if (bus.o_bit_index !== 4'd8) begin
      errors++; $display("FAIL basic_index8: got %0d want 8", bus.o_bit_index);
    end
    checks++;
    if (done_count - d0 !== 1) begin
      errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_count - d0);
    end
  endtask

  task automatic test_overclock();
    int   d0;
    logic e;
    bus.i_button_state = 8'b0101_0010;
    push_read(8'b0101_0010);
    d0 = done_count;
    host_latch();
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.o_serial_data !== e) begin
          errors++; $display("FAIL over_bit%0d: got %b want %b", i, bus.o_serial_data, e);
        end
      end
      host_clock();
      if (i >= 8) begin
        checks++;
        if (bus.o_serial_data !== 1'b0 || bus.o_bit_index !== 4'd8) begin
          errors++;
          $display("FAIL over_clk%0d: got data=%b idx=%0d want data=0 idx=8",
                   i + 1, bus.o_serial_data, bus.o_bit_index);
        end
      end
    end
    checks++;
    if (done_count - d0 !== 1) begin
      errors++; $display("FAIL over_done_pulses: got %0d want 1", done_count - d0);
    end
  endtask

  task automatic test_abort_reload();
    int   d0;
    logic e;
    bus.i_button_state = 8'hFF;
    push_read(8'hFF);
    d0 = done_count;
    host_latch();
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.o_serial_data !== e) begin
        errors++; $display("FAIL abort_bit%0d: got %b want %b", i, bus.o_serial_data, e);
      end
      host_clock();
    end
    exp_q.delete();
    bus.i_button_state = 8'h80;
    push_read(8'h80);
    host_latch();
    checks++;
    if (done_count - d0 !== 0) begin
      errors++; $display("FAIL abort_no_done: got %0d want 0", done_count - d0);
    end
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.o_serial_data !== e) begin
        errors++; $display("FAIL reload_bit%0d: got %b want %b", i, bus.o_serial_data, e);
      end
      host_clock();
      if (i == 6) begin
        checks++;
        if (done_count - d0 !== 0) begin
          errors++; $display("FAIL reload_early_done: got %0d want 0", done_count - d0);
        end
      end
    end
    checks++;
    if (done_count - d0 !== 1) begin
      errors++; $display("FAIL reload_done: got %0d want 1", done_count - d0);
    end
  endtask

  task automatic test_reset_mid_read();
    int d0;
    bus.i_button_state = 8'h3C;
    host_latch();
    for (int i = 0; i < 5; i++) host_clock();
    checks++;
    if (bus.o_bit_index !== 4'd5) begin
      errors++; $display("FAIL midrst_index5: got %0d want 5", bus.o_bit_index);
    end
    d0 = done_count;
    i_rst = 1'b1;
    wait_cyc(1);
    i_rst = 1'b0;
    checks++;
    if (bus.o_serial_data !== 1'b1 || bus.o_bit_index !== 4'd0) begin
      errors++;
      $display("FAIL midrst_state: got data=%b idx=%0d want data=1 idx=0",
               bus.o_serial_data, bus.o_bit_index);
    end
    for (int i = 0; i < 4; i++) host_clock();
    checks++;
    if (bus.o_serial_data !== 1'b1 || bus.o_bit_index !== 4'd0 || done_count != d0) begin
      errors++;
      $display("FAIL midrst_ignore: got data=%b idx=%0d dones=%0d want data=1 idx=0 dones=0",
               bus.o_serial_data, bus.o_bit_index, done_count - d0);
    end
  endtask

  task automatic test_live_load();
    logic e;
    bus.i_button_state = 8'h00;
    bus.i_data_latch = 1'b1;
    wait_cyc(6);
    checks++;
    if (bus.o_serial_data !== 1'b1) begin
      errors++; $display("FAIL live_released: got %b want 1", bus.o_serial_data);
    end
    bus.i_button_state = 8'h01;
    wait_cyc(1);
    checks++;
    if (bus.o_serial_data !== 1'b0) begin
      errors++; $display("FAIL live_pressed: got %b want 0", bus.o_serial_data);
    end
    push_read(8'h01);
    wait_cyc(2);
    bus.i_data_latch = 1'b0;
    wait_cyc(HALF);
    bus.i_button_state = 8'h00;
    wait_cyc(4);
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.o_serial_data !== e) begin
        errors++; $display("FAIL frozen_bit%0d: got %b want %b", i, bus.o_serial_data, e);
      end
      host_clock();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic       e;
    int         d0;
    for (int r = 0; r < 4; r++) begin
      b = 8'($urandom);
      bus.i_button_state = b;
      push_read(b);
      d0 = done_count;
      host_latch();
      for (int i = 0; i < 8; i++) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.o_serial_data !== e) begin
          errors++;
          $display("FAIL b2b_r%0d_bit%0d: got %b want %b (buttons %h)", r, i, bus.o_serial_data, e, b);
        end
        host_clock();
      end
      checks++;
      if (done_count - d0 !== 1) begin
        errors++; $display("FAIL b2b_r%0d_done: got %0d want 1", r, done_count - d0);
      end
    end
  endtask

`ifdef NESPAD_TURBO_EN
  task automatic test_turbo();
    logic e;
    i_rst = 1'b1;
    wait_cyc(1);
    i_rst = 1'b0;
    bus.i_button_state = 8'h01;
    bus.i_turbo = 2'b01;
    for (int k = 0; k < 8; k++) exp_q.push_back(((k / TP) % 2) == 0 ? 1'b1 : 1'b0);
    for (int k = 0; k < 8; k++) begin
      host_latch();
      e = exp_q.pop_front();
      checks++;
      if (bus.o_serial_data !== e) begin
        errors++; $display("FAIL turbo_read%0d: got %b want %b", k, bus.o_serial_data, e);
      end
      for (int i = 0; i < 8; i++) host_clock();
    end
    bus.i_turbo = 2'b00;
  endtask
`else
  task automatic test_turbo();
    logic e;
    bus.i_button_state = 8'h03;
    bus.i_turbo = 2'b11;
    push_read(8'h03);
    for (int r = 0; r < 3; r++) begin
      if (r > 0) push_read(8'h03);
      host_latch();
      for (int i = 0; i < 8; i++) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.o_serial_data !== e) begin
          errors++; $display("FAIL noturbo_r%0d_bit%0d: got %b want %b", r, i, bus.o_serial_data, e);
        end
        host_clock();
      end
    end
    bus.i_turbo = 2'b00;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_read();
    test_overclock();
    test_abort_reload();
    test_reset_mid_read();
    test_live_load();
    test_back_to_back();
    test_turbo();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nes_pad_responder.md
# nes_pad_responder

Controller-side end of the NES classic gamepad serial protocol: emulates the 4021 shift register of a standard pad so that a console, or any host that drives latch and data clock, can read an 8-bit button vector supplied by the rest of the design. It sits between a button source (a USB/BT pad bridge or on-chip test logic) and the physical pad connector pins. It synchronises the host's latch and clock, parallel-loads on latch, and shifts bits A..Right out on data-clock rising edges.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on `i_data_latch` and `i_data_clock` (minimum 2).
- `TURBO_PERIOD`, default 4: number of latch falling edges per turbo half-phase (minimum 1). Used only with the turbo build.
- `i_clk` in, 1 bit: system clock (27 MHz nominal).
- `i_rst` in, 1 bit: reset.
  - One clock; reset is synchronous and active-high.
- `i_data_latch` in, 1 bit: latch from host, asynchronous, active-high.
- `i_data_clock` in, 1 bit: data clock from host, asynchronous, shift on rising edge.
- `i_button_state` in, 8 bits: pressed = 1; bit0 A, then B, Select, Start, Up, Down, Left, bit7 Right.
- `i_turbo` in, 2 bits: bit0 turbo A, bit1 turbo B.
- `o_serial_data` out, 1 bit: data line to host; low = pressed.
- `o_bit_index` out, 4 bits: index of the bit currently presented (0..7); 8 once all bits are shifted.
- `o_read_done` out, 1 bit: one-cycle pulse when the 8th bit has been clocked out.

## Operation
- Inputs pass through a `SYNC_STAGES` synchroniser, then a 1-flop edge detector. All decisions use the synchronised signals.
- The shift register `sr[7:0]` holds the inverted (line-level) bits. `o_serial_data` = `sr[0]` except in IDLE and DONE.
- IDLE (after reset):
  - `sr`=8'hFF, `o_serial_data`=1, `o_bit_index`=0.
  - Synchronised latch high -> LOAD.
- LOAD:
  - Every cycle, `sr` <= ~masked buttons, so `o_serial_data` tracks ~A live.
  - Clock edges are ignored.
  - Latch falling edge -> SHIFT, with `o_bit_index`=0 and `sr` frozen at the last loaded value.
- SHIFT:
  - Each clock rising edge does `sr` <= {1'b0, `sr[7:1]`} and increments `o_bit_index`.
  - When the index reaches 8 -> DONE and pulse `o_read_done`.
- DONE:
  - `o_serial_data`=0 (line low; the host reads 1s, matching an official pad).
  - Further clock edges are ignored and `o_bit_index` holds at 8.
- Latch rising edge in any state -> LOAD, aborting any shift in progress. No `o_read_done` is issued for an aborted read.
- If a latch falling edge and a clock rising edge are detected in the same cycle, the latch edge wins and that clock edge is discarded.
- Masked buttons = `i_button_state`, with turbo masking applied only in the turbo build.
- Reset mid-read: returns to IDLE on the next edge of `i_clk`, and the synchroniser flops clear to 0.

## Timing
- Pin-to-output latency: `SYNC_STAGES` + 2 `i_clk` cycles from a host edge to the `o_serial_data` change. This is 4 cycles at the default, about 150 ns at 27 MHz, well inside the ~6 µs host half-period.
- Host pulses shorter than `SYNC_STAGES`+1 cycles may be missed; the minimum legal host high/low time is 4 cycles.
- `o_read_done` is asserted in the same cycle `o_bit_index` becomes 8.
- Reset values:
  - `o_serial_data`=1
  - `o_bit_index`=0
  - `o_read_done`=0

## Configuration
- `NESPAD_TURBO_EN` defined:
  - A turbo phase bit and a latch-fall counter (width $clog2(`TURBO_PERIOD`)+1) are built in.
  - The phase toggles after every `TURBO_PERIOD` latch falling edges.
  - While the phase is 0, A is forced released if `i_turbo[0]`, and B is forced released if `i_turbo[1]`.
  - Counter and phase reset to 0.
- Not defined:
  - No counter or phase logic is built.
  - `i_turbo` is ignored, and masked buttons = `i_button_state`.

## Test plan
- Reset, then `i_button_state`=8'b0000_1001 (A+Start), latch pulse, 8 clocks -> line bits 0,1,1,0,1,1,1,1; `o_read_done` pulses once; `o_serial_data`=0 afterwards.
- 12 clocks after the latch -> clocks 9..12 leave `o_serial_data`=0 and `o_bit_index`=8, with no second `o_read_done`.
- Latch reasserted after 3 clocks with the buttons changed to 8'h80 -> reload; the next read yields 1,1,1,1,1,1,1,0 and `o_read_done` only at its end.
- `i_rst` held for 1 cycle at bit 5 -> next cycle `o_serial_data`=1, `o_bit_index`=0; later clocks are ignored until a new latch.
- Buttons change while latch high (8'h00 -> 8'h01) -> `o_serial_data` falls 1->0 within 1 cycle of the change; latch fall freezes A=pressed.
- `NESPAD_TURBO_EN`, `TURBO_PERIOD`=2, A held, `i_turbo`=2'b01, 8 reads -> A read as pressed/released pattern R,R,P,P,R,R,P,P.
